onewire_txn_seq: RTL and testbench
==================================

ONEWIRE_TXN_SEQ -- requirements
Module: onewire_txn_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 4, width of byte-count fields (max 15 bytes per phase).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2048, cycles allowed from bit_start to bit_done before abort.
REQ-003 SHALL have ports: clk input 1, clock; rst input 1, reset (asynchronous, active-high).
REQ-004 SHALL have ports: req_valid input 1, req_ready output 1, transaction request handshake.
REQ-005 SHALL have ports: req_reset input 1, req_wr_len input LEN_W, req_rd_len input LEN_W; reset-phase flag, write and read byte counts.
REQ-006 SHALL have ports: wr_data input 8, wr_valid input 1, wr_ready output 1; write byte stream.
REQ-007 SHALL have ports: rd_data output 8, rd_valid output 1, rd_ready input 1; read byte stream.
REQ-008 SHALL have ports: bit_cmd output 2, bit_start output 1, bit_busy input 1, bit_done input 1, bit_presence input 1, bit_data input 1; bit-engine side.
REQ-009 SHALL have ports: busy output 1, txn_done output 1, err_nopres output 1, err_timeout output 1; status.

Function
REQ-010 Bit command encoding SHALL be 00 reset/presence, 01 write-1, 10 write-0, 11 read.
REQ-011 States SHALL be IDLE, RST_ISSUE, RST_WAIT, WR_LOAD, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_PUSH, DONE.
REQ-012 req_ready SHALL be 1 only in IDLE; request accepted on req_valid&&req_ready; lengths and flag latched that cycle.
REQ-013 From IDLE, accept SHALL go to RST_ISSUE if req_reset, else WR_LOAD if wr_len>0, else RD_ISSUE if rd_len>0, else DONE.
REQ-014 *_ISSUE states SHALL assert bit_start for exactly one cycle when bit_busy=0, then enter matching *_WAIT; if bit_busy=1, stay in ISSUE, no pulse.
REQ-015 bit_cmd SHALL be driven from ISSUE entry and held constant until the bit_done cycle inclusive; 00 in IDLE.
REQ-016 RST_WAIT on bit_done: bit_presence=0 -> DONE with err_nopres; else proceed per REQ-013 remaining phases.
REQ-017 WR_LOAD SHALL assert wr_ready; on wr_valid capture byte, bit index 0, go WR_ISSUE; no timeout while waiting.
REQ-018 Writes SHALL be LSB first; bit_cmd = 01 for bit value 1, 10 for 0.
REQ-019 WR_WAIT on bit_done: bit index<7 -> WR_ISSUE next bit; bit 7 -> WR_LOAD if bytes remain, else RD_ISSUE if rd_len>0, else DONE.
REQ-020 RD_WAIT on bit_done SHALL sample bit_data into bit position = bit index (LSB first); after bit 7 go RD_PUSH.
REQ-021 RD_PUSH SHALL hold rd_valid=1 and rd_data stable until rd_ready; then RD_ISSUE if bytes remain, else DONE.
REQ-022 Timeout counter SHALL clear in every ISSUE state, increment each WAIT cycle; reaching TIMEOUT_CYC without bit_done -> DONE with err_timeout, remaining bytes abandoned.
REQ-023 DONE SHALL last one cycle with txn_done=1; err_nopres/err_timeout valid that cycle only, 0 otherwise; next state IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Zero-length, no-reset request SHALL give txn_done exactly 1 cycle after acceptance.
REQ-026 bit_done arriving in a non-WAIT state SHALL be ignored.

Reset
REQ-027 rst SHALL force IDLE asynchronously, at any point mid-transaction; all outputs 0 except req_ready=1; counters, shift register, latched lengths cleared.
REQ-028 No partial byte or pending rd_valid SHALL survive reset.

Structure
REQ-029 Bit command encodings and state encoding SHALL live in shared package onewire_pkg.
REQ-030 One sub-module onewire_byte_shreg (8-bit LSB-first shift register with 3-bit index, load/shift/capture) SHALL serve both write and read phases.

Verification
REQ-031 Reset+write 0xCC, engine model presence=1 -> bit_cmd sequence 00,10,10,01,01,10,10,01,01; one txn_done, no errors.
REQ-032 Read 2 bytes, model returns 0xA5 then 0x3C -> rd_data 0xA5 then 0x3C; rd_ready held low 5 cycles keeps rd_valid/rd_data stable.
REQ-033 req_reset=1, wr_len=2, presence=0 -> txn_done with err_nopres=1, zero write bit_starts, wr_ready never asserted.
REQ-034 Model withholds bit_done on bit 3 of a write -> txn_done with err_timeout=1 exactly TIMEOUT_CYC cycles after that bit_start.
REQ-035 rst asserted in RD_WAIT of byte 1 -> same cycle IDLE, rd_valid=0, busy=0; next request completes normally.
REQ-036 Request with all lengths 0, req_reset=0 -> txn_done 1 cycle after accept, no bit_start.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared encodings for the 1-Wire transaction sequencer: bit-engine commands and FSM states.
package onewire_pkg;

    typedef enum logic [1:0] {
        CMD_RESET = 2'b00,
        CMD_WR1   = 2'b01,
        CMD_WR0   = 2'b10,
        CMD_READ  = 2'b11
    } bit_cmd_e;

    typedef enum logic [3:0] {
        IDLE,
        RST_ISSUE,
        RST_WAIT,
        WR_LOAD,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        RD_PUSH,
        DONE
    } state_e;

    function automatic bit_cmd_e wr_cmd(input logic bit_val);
        return bit_val ? CMD_WR1 : CMD_WR0;
    endfunction

endpackage

// File: rtl/onewire_byte_shreg.sv
// 8-bit LSB-first shift register shared by the write and read phases.
// Writes present data_q[0] and shift right; reads shift the sampled bit in at the MSB.
module onewire_byte_shreg
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic       bit_i,
    input  logic [7:0] load_data_i,
    output logic [7:0] data_o,
    output logic       lsb_o,
    output logic       last_o
);

    logic [7:0] data_q;
    logic [2:0] idx_q;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
        end else if (clear_i) begin
            data_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
            idx_q  <= '0;
        end else if (shift_i) begin
            data_q <= {bit_i, data_q[7:1]};
            idx_q  <= idx_q + 3'd1;
        end
    end

    assign data_o = data_q;
    assign lsb_o  = data_q[0];
    assign last_o = (idx_q == 3'd7);

endmodule

// File: rtl/onewire_txn_seq.sv
// 1-Wire transaction sequencer: optional reset/presence, N write bytes, M read bytes,
// each bit delegated to an external bit engine with a per-bit timeout.
module onewire_txn_seq
    import onewire_pkg::*;
#(
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_reset,
    input  logic [LEN_W-1:0] req_wr_len,
    input  logic [LEN_W-1:0] req_rd_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [1:0]       bit_cmd,
    output logic             bit_start,
    input  logic             bit_busy,
    input  logic             bit_done,
    input  logic             bit_presence,
    input  logic             bit_data,
    output logic             busy,
    output logic             txn_done,
    output logic             err_nopres,
    output logic             err_timeout
);

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   wr_left_q, wr_left_d;
    logic [LEN_W-1:0]   rd_left_q, rd_left_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               nopres_q, nopres_d;
    logic               tmo_q, tmo_d;

    logic               sr_clear, sr_load, sr_shift, sr_bit;
    logic [7:0]         sr_data;
    logic               sr_lsb, sr_last;
    logic               in_wait, in_issue, timed_out;

    onewire_byte_shreg u_shreg (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (sr_clear),
        .load_i      (sr_load),
        .shift_i     (sr_shift),
        .bit_i       (sr_bit),
        .load_data_i (wr_data),
        .data_o      (sr_data),
        .lsb_o       (sr_lsb),
        .last_o      (sr_last)
    );

    function automatic state_e next_phase(input logic [LEN_W-1:0] wr_len,
                                          input logic [LEN_W-1:0] rd_len);
        if (wr_len != '0) return WR_LOAD;
        if (rd_len != '0) return RD_ISSUE;
        return DONE;
    endfunction

    assign in_wait  = (state_q == RST_WAIT)  || (state_q == WR_WAIT)  || (state_q == RD_WAIT);
    assign in_issue = (state_q == RST_ISSUE) || (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
    // tmr_q+1 cycles have elapsed since bit_start; abort so DONE lands TIMEOUT_CYC after the pulse.
    assign timed_out = (tmr_q == TMR_W'(TIMEOUT_CYC - 2));

    // NOTE: every output and next-state signal gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        wr_left_d   = wr_left_q;
        rd_left_d   = rd_left_q;
        tmr_d       = tmr_q;
        nopres_d    = nopres_q;
        tmo_d       = tmo_q;
        sr_clear    = 1'b0;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_bit      = 1'b0;
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        rd_valid    = 1'b0;
        rd_data     = '0;
        bit_cmd     = CMD_RESET;
        bit_start   = 1'b0;
        busy        = 1'b1;
        txn_done    = 1'b0;
        err_nopres  = 1'b0;
        err_timeout = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    wr_left_d = req_wr_len;
                    rd_left_d = req_rd_len;
                    nopres_d  = 1'b0;
                    tmo_d     = 1'b0;
                    sr_clear  = 1'b1;
                    state_d   = req_reset ? RST_ISSUE : next_phase(req_wr_len, req_rd_len);
                end
            end
            RST_ISSUE, RST_WAIT: begin
                bit_cmd = CMD_RESET;
                if (state_q == RST_ISSUE) begin
                    if (!bit_busy) begin
                        bit_start = 1'b1;
                        state_d   = RST_WAIT;
                    end
                end else if (bit_done) begin
                    if (!bit_presence) begin
                        nopres_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = next_phase(wr_left_q, rd_left_q);
                    end
                end
            end
            WR_LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    sr_load   = 1'b1;
                    wr_left_d = wr_left_q - 1'b1;
                    state_d   = WR_ISSUE;
                end
            end
            WR_ISSUE, WR_WAIT: begin
                // The shift happens on the bit_done edge, so the command holds through that cycle.
                bit_cmd = wr_cmd(sr_lsb);
                if (state_q == WR_ISSUE) begin
                    if (!bit_busy) begin
                        bit_start = 1'b1;
                        state_d   = WR_WAIT;
                    end
                end else if (bit_done) begin
                    sr_shift = 1'b1;
                    state_d  = sr_last ? next_phase(wr_left_q, rd_left_q) : WR_ISSUE;
                end
            end
            RD_ISSUE, RD_WAIT: begin
                bit_cmd = CMD_READ;
                if (state_q == RD_ISSUE) begin
                    if (!bit_busy) begin
                        bit_start = 1'b1;
                        state_d   = RD_WAIT;
                    end
                end else if (bit_done) begin
                    sr_shift = 1'b1;
                    sr_bit   = bit_data;
                    state_d  = sr_last ? RD_PUSH : RD_ISSUE;
                end
            end
            RD_PUSH: begin
                rd_valid = 1'b1;
                rd_data  = sr_data;
                if (rd_ready) begin
                    rd_left_d = rd_left_q - 1'b1;
                    state_d   = (rd_left_q > 1) ? RD_ISSUE : DONE;
                end
            end
            DONE: begin
                txn_done    = 1'b1;
                err_nopres  = nopres_q;
                err_timeout = tmo_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (in_issue) tmr_d = '0;
        if (in_wait && !bit_done) begin
            if (timed_out) begin
                tmo_d   = 1'b1;
                state_d = DONE;
            end else begin
                tmr_d   = tmr_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_left_q <= '0;
            rd_left_q <= '0;
            tmr_q     <= '0;
            nopres_q  <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_left_q <= wr_left_d;
            rd_left_q <= rd_left_d;
            tmr_q     <= tmr_d;
            nopres_q  <= nopres_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

// File: tb/tb_onewire_txn_seq.sv
// Self-checking bench: behavioural bit-engine model plus a transaction-level reference model.
module tb_onewire_txn_seq;

    localparam int LEN_W       = 4;
    localparam int TIMEOUT_CYC = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_reset;
    logic [LEN_W-1:0] req_wr_len, req_rd_len;
    logic [7:0]       wr_data;
    logic             wr_valid, wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid, rd_ready;
    logic [1:0]       bit_cmd;
    logic             bit_start, bit_busy, bit_done, bit_presence, bit_data;
    logic             busy, txn_done, err_nopres, err_timeout;

    always #5 clk = ~clk;

    onewire_txn_seq #(.LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_reset(req_reset),
        .req_wr_len(req_wr_len), .req_rd_len(req_rd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .bit_cmd(bit_cmd), .bit_start(bit_start), .bit_busy(bit_busy), .bit_done(bit_done),
        .bit_presence(bit_presence), .bit_data(bit_data),
        .busy(busy), .txn_done(txn_done), .err_nopres(err_nopres), .err_timeout(err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the expected command stream, read bytes and error outcome of one request.
    logic [7:0] wr_bytes[16];
    logic [7:0] rd_bytes[16];
    logic [1:0] exp_cmds[$];
    logic [7:0] exp_rd[$];
    int         exp_loads;
    bit         exp_nopres, exp_tmo;

    function automatic void build_model(input bit do_rst, input int wr_len, input int rd_len,
                                        input bit pres, input int hang);
        exp_cmds.delete();
        exp_rd.delete();
        exp_loads  = 0;
        exp_nopres = 1'b0;
        exp_tmo    = 1'b0;
        if (do_rst) begin
            exp_cmds.push_back(2'b00);
            if (hang == 0) begin exp_tmo = 1'b1; return; end
            if (!pres) begin exp_nopres = 1'b1; return; end
        end
        for (int b = 0; b < wr_len; b++) begin
            exp_loads++;
            for (int i = 0; i < 8; i++) begin
                exp_cmds.push_back(wr_bytes[b][i] ? 2'b01 : 2'b10);
                if (exp_cmds.size() - 1 == hang) begin exp_tmo = 1'b1; return; end
            end
        end
        for (int b = 0; b < rd_len; b++) begin
            for (int i = 0; i < 8; i++) begin
                exp_cmds.push_back(2'b11);
                if (exp_cmds.size() - 1 == hang) begin exp_tmo = 1'b1; return; end
            end
            exp_rd.push_back(rd_bytes[b]);
        end
    endfunction

    task automatic quiet_inputs();
        req_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        bit_busy = 1'b0; bit_done = 1'b0; bit_presence = 1'b0; bit_data = 1'b0;
    endtask

    // One request end to end. hang: index of the bit the engine never finishes (-1 none);
    // rst_after: assert rst while waiting on a read bit once this many read bits started (-1 none).
    task automatic run_txn(input bit do_rst, input int wr_len, input int rd_len, input bit pres,
                           input int hang, input int stall, input bit rand_hs, input int rst_after);
        int n_start = 0, n_rd_start = 0, n_rdbit = 0, n_load = 0;
        int eng_wait = 0, eng_rec = 0, cyc = 0, acc_cyc = -1, hang_cyc = -1;
        int stall_left = stall;
        bit eng_act = 0, eng_hang = 0, done_now = 0, fin = 0, accepted = 0;
        bit prev_start = 0, prev_acc = 0, prev_wr_hs = 0, prev_rdv = 0, prev_rdy = 0;
        logic [1:0] eng_cmd = 2'b00, next_cmd = 2'b00;
        logic [7:0] prev_rdd = 8'h00;

        build_model(do_rst, wr_len, rd_len, pres, hang);
        req_reset  = do_rst;
        req_wr_len = LEN_W'(wr_len);
        req_rd_len = LEN_W'(rd_len);

        while (!fin) begin
            @(posedge clk); #1; cyc++;
            if (prev_acc) accepted = 1'b1;
            req_valid = !accepted;

            if (prev_wr_hs) begin n_load++; wr_valid = 1'b0; end
            if (!wr_valid && n_load < wr_len) begin
                wr_data  = wr_bytes[n_load];
                wr_valid = rand_hs ? ($urandom_range(0, 1) == 1) : 1'b1;
            end

            if (prev_rdv && prev_rdy) stall_left = stall;
            else if (prev_rdv && stall_left > 0) stall_left--;
            rd_ready = (stall_left == 0) && (rand_hs ? ($urandom_range(0, 1) == 1) : 1'b1);

            if (prev_start) begin
                eng_act  = 1'b1;
                eng_cmd  = next_cmd;
                eng_hang = (n_start - 1 == hang);
                eng_wait = $urandom_range(1, 3);
            end
            done_now = 1'b0; bit_done = 1'b0; bit_presence = 1'b0; bit_data = 1'b0;
            if (eng_act) begin
                bit_busy = 1'b1;
                if (!eng_hang) eng_wait--;
                if (!eng_hang && eng_wait == 0) begin
                    done_now = 1'b1; bit_done = 1'b1; eng_act = 1'b0;
                    eng_rec  = $urandom_range(0, 2);
                    if (eng_cmd == 2'b00) bit_presence = pres;
                    if (eng_cmd == 2'b11 && n_rdbit < 128) begin
                        bit_data = rd_bytes[n_rdbit / 8][n_rdbit % 8];
                        n_rdbit++;
                    end
                end
            end else if (eng_rec > 0) begin
                bit_busy = 1'b1;
                eng_rec--;
            end else begin
                bit_busy = 1'b0;
                if (rand_hs && $urandom_range(0, 7) == 0) begin
                    bit_done     = 1'b1;
                    bit_presence = ($urandom_range(0, 1) == 1);
                    bit_data     = ($urandom_range(0, 1) == 1);
                end
            end

            if (rst_after >= 0 && eng_act && !done_now && eng_cmd == 2'b11 && n_rd_start > rst_after) begin
                rst = 1'b1;
                #1;
                check("midrst_busy", 32'(busy), 32'd0);
                check("midrst_rd_valid", 32'(rd_valid), 32'd0);
                check("midrst_req_ready", 32'(req_ready), 32'd1);
                check("midrst_bit_start", 32'(bit_start), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                quiet_inputs();
                return;
            end

            #1;
            if (!txn_done) check("err_outside_done", 32'({err_nopres, err_timeout}), 32'd0);
            if (accepted) check("busy_in_txn", 32'({busy, req_ready}), 32'b10);
            if (done_now) check("bit_cmd_held", 32'(bit_cmd), 32'(eng_cmd));
            if (bit_start) begin
                check("start_while_busy", 32'(bit_busy), 32'd0);
                if (n_start < exp_cmds.size()) begin
                    check("bit_cmd_seq", 32'(bit_cmd), 32'(exp_cmds[n_start]));
                    next_cmd = exp_cmds[n_start];
                end else begin
                    check("extra_bit_start", 32'(n_start), 32'(exp_cmds.size()));
                    next_cmd = bit_cmd;
                end
                if (n_start == hang) hang_cyc = cyc;
                if (bit_cmd == 2'b11) n_rd_start++;
                n_start++;
            end
            prev_start = bit_start;
            prev_wr_hs = wr_valid && wr_ready;

            if (prev_rdv && !prev_rdy) begin
                check("rd_valid_held", 32'(rd_valid), 32'd1);
                check("rd_data_stable", 32'(rd_data), 32'(prev_rdd));
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
                else check("extra_rd_byte", 32'(rd_valid), 32'd0);
            end
            prev_rdv = rd_valid; prev_rdy = rd_ready; prev_rdd = rd_data;

            prev_acc = req_valid && req_ready;
            if (prev_acc) acc_cyc = cyc;

            if (txn_done) begin
                check("err_nopres", 32'(err_nopres), 32'(exp_nopres));
                check("err_timeout", 32'(err_timeout), 32'(exp_tmo));
                if (exp_tmo) check("timeout_latency", 32'(cyc - hang_cyc), 32'(TIMEOUT_CYC));
                if (!do_rst && wr_len == 0 && rd_len == 0)
                    check("zero_len_latency", 32'(cyc - acc_cyc), 32'd1);
                fin = 1'b1;
            end else if (cyc > TIMEOUT_CYC + 800) begin
                check("txn_cycle_budget", 32'(txn_done), 32'd1);
                fin = 1'b1;
            end
        end
        if (prev_wr_hs) n_load++;

        @(posedge clk); #1;
        quiet_inputs();
        #1;
        check("done_one_cycle", 32'({txn_done, req_ready}), 32'b01);
        check("bit_start_count", 32'(n_start), 32'(exp_cmds.size()));
        check("rd_bytes_left", 32'(exp_rd.size()), 32'd0);
        check("wr_bytes_loaded", 32'(n_load), 32'(exp_loads));
    endtask

    initial begin
        rst = 1'b1;
        req_reset = 1'b0; req_wr_len = '0; req_rd_len = '0; wr_data = '0;
        quiet_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({req_ready, busy, txn_done, rd_valid, wr_ready, bit_start,
                                  err_nopres, err_timeout}), 32'b1000_0000);
        check("rst_bit_cmd", 32'(bit_cmd), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_idle", 32'({req_ready, busy}), 32'b10);

        // Reset then write 0xCC with presence.
        wr_bytes[0] = 8'hCC;
        run_txn(1'b1, 1, 0, 1'b1, -1, 0, 1'b0, -1);

        // Two-byte read with a 5-cycle consumer stall.
        rd_bytes[0] = 8'hA5; rd_bytes[1] = 8'h3C;
        run_txn(1'b0, 0, 2, 1'b1, -1, 5, 1'b0, -1);

        // No presence: writes abandoned before any byte is taken.
        wr_bytes[0] = 8'h5A; wr_bytes[1] = 8'h81;
        run_txn(1'b1, 2, 0, 1'b0, -1, 0, 1'b0, -1);

        // Engine never finishes bit 3 of the first write byte.
        wr_bytes[0] = 8'($urandom); wr_bytes[1] = 8'($urandom);
        run_txn(1'b0, 2, 0, 1'b1, 3, 0, 1'b0, -1);

        // Reset mid-read, then a normal transaction.
        rd_bytes[0] = 8'($urandom); rd_bytes[1] = 8'($urandom);
        run_txn(1'b1, 0, 2, 1'b1, -1, 0, 1'b0, 3);
        wr_bytes[0] = 8'($urandom);
        rd_bytes[0] = 8'($urandom); rd_bytes[1] = 8'($urandom);
        run_txn(1'b1, 1, 2, 1'b1, -1, 2, 1'b1, -1);

        // Empty request.
        run_txn(1'b0, 0, 0, 1'b1, -1, 0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            bit do_rst, pres;
            int wl, rl, total, hang;
            do_rst = ($urandom_range(0, 1) == 1);
            pres   = ($urandom_range(0, 3) != 0);
            wl     = $urandom_range(0, 3);
            rl     = $urandom_range(0, 3);
            total  = (do_rst ? 1 : 0) + 8 * (wl + rl);
            hang   = (total > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, total - 1) : -1;
            for (int b = 0; b < 16; b++) begin
                wr_bytes[b] = 8'($urandom);
                rd_bytes[b] = 8'($urandom);
            end
            run_txn(do_rst, wl, rl, pres, hang, $urandom_range(0, 3), 1'b1, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
